shift_add_mult16: RTL and testbench



---
 rtl/arith_pkg.sv | 15 +
 rtl/shift_add_mult16_if.sv | 18 +
 rtl/add16_cout.sv | 28 ++
 rtl/shift_add_mult16.sv | 93 +++++++++
 tb/tb_shift_add_mult16.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/arith_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM states, default
// operand width and iteration counter sizing.
package arith_pkg;

    localparam int W_DEF = 16;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_add_mult16_if.sv
// Start/ready/done handshake and operand/product bus of the multiplier.
interface shift_add_mult16_if
    import arith_pkg::*;
#(
    parameter int W = W_DEF
);
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           done;
    logic [2*W-1:0] product;

    modport master (output start, output a, output b,
                    input ready, input done, input product);
    modport slave  (input start, input a, input b,
                    output ready, output done, output product);
endinterface

// File: rtl/add16_cout.sv
// Combinational W-bit ripple-carry adder with carry in and carry out; the
// single adder datapath shared by the multiplier.
module add16_cout
    import arith_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
    end

    assign cout = c[W];

endmodule

// File: rtl/shift_add_mult16.sv
// Sequential unsigned W x W -> 2W shift-and-add multiplier: one conditional
// add and one right shift of the {hi, lo} accumulator per clock.
module shift_add_mult16
    import arith_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    shift_add_mult16_if.slave bus_io
);
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     mcand_q, mcand_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [W-1:0]     lo_q, lo_d;
    logic [2*W-1:0]   product_q, product_d;

    logic [W-1:0]     addend;
    logic [W-1:0]     sum;
    logic             cout;
    logic [2*W-1:0]   shifted;

    assign addend = lo_q[0] ? mcand_q : '0;

    add16_cout #(.W(W)) u_add (
        .x    (hi_q),
        .y    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // The adder carry becomes the new hi MSB, so no product bit is lost.
    assign shifted = {cout, sum, lo_q[W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_io.start) begin
                    state_d = ST_RUN;
                    mcand_d = bus_io.a;
                    hi_d    = '0;
                    lo_d    = bus_io.b;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                {hi_d, lo_d} = shifted;
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = ST_FIN;
                    product_d = shifted;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_io.ready   = (state_q == ST_IDLE);
    assign bus_io.done    = (state_q == ST_FIN);
    assign bus_io.product = product_q;

endmodule

// File: tb/tb_shift_add_mult16.sv
// Directed and randomized bench for shift_add_mult16; expected products come
// from plain 32-bit multiplication and timing from the handshake rules.
module tb_shift_add_mult16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    shift_add_mult16_if #(.W(16)) bus_if ();

    shift_add_mult16 #(.W(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv);
        chk({tag, "_ready_idle"}, 32'(bus_if.ready), 32'd1);
        bus_if.start = 1'b1;
        bus_if.a     = av;
        bus_if.b     = bv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input string tag, output int at);
        int lat;
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!bus_if.done && lat < 40);
        at = cyc;
        chk({tag, "_latency"}, 32'(lat), 32'd16);
    endtask

    task automatic after_done(input string tag);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(bus_if.done), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus_if.ready), 32'd1);
    endtask

    task automatic mul(input string tag, input logic [15:0] av, input logic [15:0] bv, output int at);
        logic [31:0] exp_p;
        exp_p = 32'(av) * 32'(bv);
        start_op(tag, av, bv);
        bus_if.start = 1'b0;
        bus_if.a     = 16'($urandom);
        bus_if.b     = 16'($urandom);
        chk({tag, "_busy"}, 32'(bus_if.ready), 32'd0);
        wait_done(tag, at);
        chk({tag, "_product"}, bus_if.product, exp_p);
        after_done(tag);
    endtask

    initial begin
        int          t1;
        int          t2;
        bit          seen_done;
        logic [15:0] ra;
        logic [15:0] rb;

        bus_if.start = 1'b0;
        bus_if.a     = '0;
        bus_if.b     = '0;

        @(negedge clk);
        chk("rst_ready", 32'(bus_if.ready), 32'd1);
        chk("rst_done", 32'(bus_if.done), 32'd0);
        chk("rst_product", bus_if.product, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        mul("small", 16'h0003, 16'h0005, t1);
        chk("small_const", bus_if.product, 32'h0000_000F);

        mul("allones", 16'hFFFF, 16'hFFFF, t1);
        chk("allones_const", bus_if.product, 32'hFFFE_0001);

        mul("zero_b", 16'h1234, 16'h0000, t1);
        mul("zero_a", 16'h0000, 16'hABCD, t1);

        // start held through RUN/FIN: second operands only taken once idle again
        start_op("hold", 16'h00FF, 16'h0100);
        bus_if.a = 16'hFFFF;
        bus_if.b = 16'hFFFF;
        wait_done("hold", t1);
        chk("hold_product", bus_if.product, 32'h0000_FF00);
        after_done("hold");
        @(posedge clk);
        @(negedge clk);
        bus_if.start = 1'b0;
        chk("hold2_busy", 32'(bus_if.ready), 32'd0);
        wait_done("hold2", t2);
        chk("hold2_product", bus_if.product, 32'hFFFE_0001);
        chk("hold2_spacing", 32'(t2 - t1), 32'd18);
        after_done("hold2");

        // reset in the middle of RUN discards the result
        start_op("abort", 16'h8000, 16'h0002);
        bus_if.start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ready", 32'(bus_if.ready), 32'd1);
        chk("abort_done", 32'(bus_if.done), 32'd0);
        chk("abort_product", bus_if.product, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus_if.done) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        chk("abort_idle_product", bus_if.product, 32'd0);
        mul("after_abort", 16'h0007, 16'h0009, t1);
        chk("after_abort_const", bus_if.product, 32'h0000_003F);

        mul("b2b_first", 16'h1234, 16'h5678, t1);
        chk("b2b_first_const", bus_if.product, 32'h0626_0060);
        mul("b2b_second", 16'hFFFF, 16'h0001, t2);
        chk("b2b_second_const", bus_if.product, 32'h0000_FFFF);
        chk("b2b_spacing", 32'(t2 - t1), 32'd18);

        for (int i = 0; i < 12; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) ra = 16'h8001;
            if (i == 1) rb = 16'hFFFF;
            mul("random", ra, rb, t1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
